// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

    typedef enum logic {IDLE, WAIT} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;

    localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side (fetch, data) and memory-side signals of the arbiter, bundled as one bus.
// Handshake: a requester raises req and holds req and all its fields stable until the
// cycle its gnt is high; exactly one rvalid follows each gnt, rvalid is a one-cycle pulse.
interface mem_arbiter_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;

    logic        d_req;
    logic        d_we;
    logic [2:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        m_req;
    logic        m_we;
    logic [2:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    // Arbiter view.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata,
        input  m_gnt, m_rvalid, m_rdata,
        output i_gnt, i_rvalid, i_rdata, i_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output m_req, m_we, m_size, m_addr, m_wdata
    );

    // Environment view: the core requesters plus the memory macro.
    modport master (
        output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata,
        output m_gnt, m_rvalid, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  m_req, m_we, m_size, m_addr, m_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  owner_e     last,
    output logic [1:0] win_o    // bit 0 = fetch, bit 1 = data
);

    always_comb begin
        win_o = 2'b00;
        if (req_i && req_d) begin
            win_o = (last == OWN_I) ? 2'b10 : 2'b01;
        end else if (req_i) begin
            win_o = 2'b01;
        end else if (req_d) begin
            win_o = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store, one
// transaction in flight, with a response timeout that returns an error.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output state_e        dbg_state_o
);

    localparam int unsigned    CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_e        state_q;
    owner_e        owner_q;
    owner_e        last_q;
    logic [CW-1:0] cnt_q;

    logic [1:0]    win;
    logic          sel_i;
    logic          sel_d;
    owner_e        win_owner;
    logic          hs;
    logic          timeout_hit;
    logic          rsp_fire;

    rr_pick2 u_pick (
        .req_i (bus.i_req),
        .req_d (bus.d_req),
        .last  (last_q),
        .win_o (win)
    );

    assign sel_i       = win[0];
    assign sel_d       = win[1];
    assign win_owner   = sel_d ? OWN_D : OWN_I;
    assign hs          = (state_q == IDLE) && (sel_i || sel_d) && bus.m_gnt;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    // A real response in the threshold cycle takes precedence over the timeout.
    assign rsp_fire    = (state_q == WAIT) && (bus.m_rvalid || timeout_hit);
    assign dbg_state_o = state_q;

    always_comb begin
        bus.i_gnt    = 1'b0;
        bus.i_rvalid = 1'b0;
        bus.i_rdata  = '0;
        bus.i_err    = 1'b0;
        bus.d_gnt    = 1'b0;
        bus.d_rvalid = 1'b0;
        bus.d_rdata  = '0;
        bus.d_err    = 1'b0;
        bus.m_req    = 1'b0;
        bus.m_we     = 1'b0;
        bus.m_size   = '0;
        bus.m_addr   = '0;
        bus.m_wdata  = '0;
        if (!rst) begin
            if (state_q == IDLE) begin
                if (sel_d) begin
                    bus.m_req   = 1'b1;
                    bus.m_we    = bus.d_we;
                    bus.m_size  = bus.d_size;
                    bus.m_addr  = bus.d_addr;
                    bus.m_wdata = bus.d_wdata;
                    bus.d_gnt   = bus.m_gnt;
                end else if (sel_i) begin
                    bus.m_req   = 1'b1;
                    bus.m_size  = SIZE_WORD;
                    bus.m_addr  = bus.i_addr;
                    bus.i_gnt   = bus.m_gnt;
                end
            end else if (rsp_fire) begin
                if (owner_q == OWN_D) begin
                    bus.d_rvalid = 1'b1;
                    bus.d_rdata  = bus.m_rvalid ? bus.m_rdata : '0;
                    bus.d_err    = !bus.m_rvalid;
                end else begin
                    bus.i_rvalid = 1'b1;
                    bus.i_rdata  = bus.m_rvalid ? bus.m_rdata : '0;
                    bus.i_err    = !bus.m_rvalid;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_I;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        owner_q <= win_owner;
                        last_q  <= win_owner;
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.m_rvalid || timeout_hit) begin
                        state_q <= IDLE;
                    end else if (TIMEOUT != 0) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter built with TIMEOUT=4.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct packed {
        logic        rst;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [2:0]  d_size;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        m_gnt;
        logic        m_rvalid;
        logic [31:0] m_rdata;
    } in_t;

    typedef struct packed {
        logic        i_gnt;
        logic        i_rvalid;
        logic [31:0] i_rdata;
        logic        i_err;
        logic        d_gnt;
        logic        d_rvalid;
        logic [31:0] d_rdata;
        logic        d_err;
        logic        m_req;
        logic        m_we;
        logic [2:0]  m_size;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst;
    state_e dbg_state;
    int     n_vec = 0;
    int     n_bad = 0;
    vec_t   vq[$];

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- vector builders ----------------
    function automatic in_t mk_in(logic r, logic ir, logic [31:0] ia, logic dr, logic dwe,
                                  logic [2:0] ds, logic [31:0] da, logic [31:0] dw,
                                  logic mg, logic mrv, logic [31:0] mrd);
        in_t v;
        v = '{rst: r, i_req: ir, i_addr: ia, d_req: dr, d_we: dwe, d_size: ds, d_addr: da,
              d_wdata: dw, m_gnt: mg, m_rvalid: mrv, m_rdata: mrd};
        return v;
    endfunction

    function automatic out_t mk_out(logic ig, logic irv, logic [31:0] ird, logic ie,
                                    logic dg, logic drv, logic [31:0] drd, logic de,
                                    logic mr, logic mwe, logic [2:0] ms,
                                    logic [31:0] ma, logic [31:0] mw);
        out_t v;
        v = '{i_gnt: ig, i_rvalid: irv, i_rdata: ird, i_err: ie, d_gnt: dg, d_rvalid: drv,
              d_rdata: drd, d_err: de, m_req: mr, m_we: mwe, m_size: ms, m_addr: ma,
              m_wdata: mw};
        return v;
    endfunction

    function automatic void add(string name, in_t in, out_t exp);
        vec_t v;
        v.name = name;
        v.in   = in;
        v.exp  = exp;
        vq.push_back(v);
    endfunction

    // ---------------- driver / monitor ----------------
    task automatic drive(input in_t v);
        rst          = v.rst;
        bus.i_req    = v.i_req;
        bus.i_addr   = v.i_addr;
        bus.d_req    = v.d_req;
        bus.d_we     = v.d_we;
        bus.d_size   = v.d_size;
        bus.d_addr   = v.d_addr;
        bus.d_wdata  = v.d_wdata;
        bus.m_gnt    = v.m_gnt;
        bus.m_rvalid = v.m_rvalid;
        bus.m_rdata  = v.m_rdata;
    endtask

    function automatic out_t sample();
        out_t a;
        a = '{i_gnt: bus.i_gnt, i_rvalid: bus.i_rvalid, i_rdata: bus.i_rdata, i_err: bus.i_err,
              d_gnt: bus.d_gnt, d_rvalid: bus.d_rvalid, d_rdata: bus.d_rdata, d_err: bus.d_err,
              m_req: bus.m_req, m_we: bus.m_we, m_size: bus.m_size, m_addr: bus.m_addr,
              m_wdata: bus.m_wdata};
        return a;
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = sample();
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got i(g%b v%b d%h e%b) d(g%b v%b d%h e%b) m(r%b w%b s%h a%h wd%h), required i(g%b v%b d%h e%b) d(g%b v%b d%h e%b) m(r%b w%b s%h a%h wd%h)",
                     name,
                     act.i_gnt, act.i_rvalid, act.i_rdata, act.i_err,
                     act.d_gnt, act.d_rvalid, act.d_rdata, act.d_err,
                     act.m_req, act.m_we, act.m_size, act.m_addr, act.m_wdata,
                     exp.i_gnt, exp.i_rvalid, exp.i_rdata, exp.i_err,
                     exp.d_gnt, exp.d_rvalid, exp.d_rdata, exp.d_err,
                     exp.m_req, exp.m_we, exp.m_size, exp.m_addr, exp.m_wdata);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        automatic out_t z = '0;
        automatic in_t  idle_in = '0;
        logic           found;
        int             lat;
        logic [31:0]    rd;

        drive(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // reset with activity on every input: all outputs must stay low
        add("rst_quiet", mk_in(1, 1, 32'h10, 1, 0, 3'd2, 32'h200, 0, 1, 1, 32'h99), z);

        // lone fetch, single-cycle memory
        add("fetch_gnt", mk_in(0, 1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0),
            mk_out(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd2, 32'h10, 0));
        add("fetch_rsp", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF),
            mk_out(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // both pending, memory always ready: D, I, D, I
        for (int k = 0; k < 4; k++) begin
            rd = 32'h1111 * (k + 1);
            if (k % 2 == 0) begin
                add("rr_gnt_d", mk_in(0, 1, 32'h20, 1, 0, 3'd2, 32'h200, 0, 1, 0, 0),
                    mk_out(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 3'd2, 32'h200, 0));
                add("rr_rsp_d", mk_in(0, 1, 32'h20, 1, 0, 3'd2, 32'h200, 0, 1, 1, rd),
                    mk_out(0, 0, 0, 0, 0, 1, rd, 0, 0, 0, 0, 0, 0));
            end else begin
                add("rr_gnt_i", mk_in(0, 1, 32'h20, 1, 0, 3'd2, 32'h200, 0, 1, 0, 0),
                    mk_out(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd2, 32'h20, 0));
                add("rr_rsp_i", mk_in(0, 1, 32'h20, 1, 0, 3'd2, 32'h200, 0, 1, 1, rd),
                    mk_out(0, 1, rd, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            end
        end

        // byte store stalled by the memory for three cycles
        for (int k = 0; k < 3; k++) begin
            add("st_stall", mk_in(0, 0, 0, 1, 1, 3'd0, 32'h100, 32'hA5, 0, 0, 0),
                mk_out(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3'd0, 32'h100, 32'hA5));
        end
        add("st_gnt", mk_in(0, 0, 0, 1, 1, 3'd0, 32'h100, 32'hA5, 1, 0, 0),
            mk_out(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 3'd0, 32'h100, 32'hA5));
        add("st_rsp", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0),
            mk_out(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

        // load that never gets a response: error exactly 4 cycles after the handshake
        add("to_gnt", mk_in(0, 0, 0, 1, 0, 3'd2, 32'h300, 0, 1, 0, 0),
            mk_out(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 3'd2, 32'h300, 0));
        for (int k = 1; k < 4; k++) add("to_wait", idle_in, z);
        add("to_err", idle_in, mk_out(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        add("late_rsp", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5555), z);

        // response arrives on the threshold cycle: data wins, no error
        add("edge_gnt", mk_in(0, 1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0),
            mk_out(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd2, 32'h40, 0));
        for (int k = 1; k < 4; k++) add("edge_wait", idle_in, z);
        add("edge_rsp", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h6666),
            mk_out(0, 1, 32'h6666, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // reset while a data load is outstanding
        add("rw_gnt", mk_in(0, 0, 0, 1, 0, 3'd2, 32'h400, 0, 1, 0, 0),
            mk_out(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 3'd2, 32'h400, 0));
        add("rw_rst", mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), z);
        add("rw_late", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h7777), z);
        add("rw_tie", mk_in(0, 1, 32'h50, 1, 0, 3'd2, 32'h500, 0, 1, 0, 0),
            mk_out(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 3'd2, 32'h500, 0));
        add("rw_rsp", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8888),
            mk_out(0, 0, 0, 0, 0, 1, 32'h8888, 0, 0, 0, 0, 0, 0));

        foreach (vq[n]) begin
            @(negedge clk);
            drive(vq[n].in);
            #1;
            check(vq[n].name, vq[n].exp);
        end

        // fetch timeout measured with a bounded wait
        @(negedge clk);
        drive(mk_in(0, 1, 32'h60, 0, 0, 0, 0, 0, 1, 0, 0));
        #1;
        check("hs_gnt", mk_out(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd2, 32'h60, 0));
        found = 1'b0;
        lat   = 0;
        for (int k = 1; k <= 10 && !found; k++) begin
            @(negedge clk);
            drive(idle_in);
            #1;
            if (bus.i_rvalid === 1'b1) begin
                found = 1'b1;
                lat   = k;
            end
        end
        n_vec++;
        if (!found || lat != 4 || bus.i_err !== 1'b1 || bus.i_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL hs_timeout: found=%0d latency=%0d err=%b rdata=%h, required found=1 latency=4 err=1 rdata=00000000",
                     found, lat, bus.i_err, bus.i_rdata);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
